// File: rtl/cpu_cu_if.sv
// Control-unit <-> execution-unit bundle: instruction/flags in, strobes out.
interface cpu_cu_if;
    logic [15:0] ir_out;
    logic        C;
    logic        N;
    logic        Z;
    logic        step;
    logic        w_en;
    logic        s_sel;
    logic        pc_ld;
    logic        pc_inc;
    logic        ir_ld;
    logic        adr_sel;
    logic        pc_sel;
    logic [2:0]  W_Adr;
    logic [2:0]  R_Adr;
    logic [2:0]  S_Adr;
    logic [3:0]  ALU_OP;
    logic        mr_en;
    logic        mw_en;
    logic        halted;
    logic [3:0]  state;

    modport master (
        input  ir_out, C, N, Z, step,
        output w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel, pc_sel,
        output W_Adr, R_Adr, S_Adr, ALU_OP, mr_en, mw_en, halted, state
    );

    modport slave (
        output ir_out, C, N, Z, step,
        input  w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel, pc_sel,
        input  W_Adr, R_Adr, S_Adr, ALU_OP, mr_en, mw_en, halted, state
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Moore FSM sequencing fetch/decode/execute for the execution unit.
// Define CU_STEP_EN to add a WAIT state released by the step input.
module cpu_control_unit #(
    parameter logic [3:0] ALU_PASS_R = 4'h0,
    parameter logic [3:0] ALU_PASS_S = 4'h1
) (
    input  logic     clk,
    input  logic     reset,
    cpu_cu_if.master bus
);
    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_ALU = 4'd3,
        S_LOAD     = 4'd4,
        S_STORE    = 4'd5,
        S_BRANCH   = 4'd6,
        S_JUMP     = 4'd7,
        S_HALT     = 4'd8,
        S_ILLEGAL  = 4'd9,
        S_WAIT     = 4'd10
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  psr_q, psr_d;
    logic [15:0] ir;
    logic        taken;
    state_e      exec_next;

    assign ir = bus.ir_out;

`ifdef CU_STEP_EN
    assign exec_next = S_WAIT;
`else
    logic unused_step;
    assign unused_step = bus.step;
    assign exec_next   = S_FETCH;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            psr_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            psr_q   <= psr_d;
        end
    end

    // Only ALU ops touch the flags; every other state holds them.
    assign psr_d = (state_q == S_EXEC_ALU) ? {bus.C, bus.N, bus.Z} : psr_q;

    always_comb begin
        taken = 1'b0;
        case (ir[11:8])
            4'h0:    taken = 1'b1;
            4'h1:    taken = psr_q[0];
            4'h2:    taken = !psr_q[0];
            4'h3:    taken = psr_q[2];
            4'h4:    taken = !psr_q[2];
            4'h5:    taken = psr_q[1];
            4'h6:    taken = !psr_q[1];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    !ir[15]:             state_d = S_EXEC_ALU;
                    ir[15:12] == 4'h8:   state_d = S_LOAD;
                    ir[15:12] == 4'h9:   state_d = S_STORE;
                    ir[15:12] == 4'hA:   state_d = S_BRANCH;
                    ir[15:12] == 4'hB:   state_d = S_JUMP;
                    ir[15:12] == 4'hF:   state_d = S_HALT;
                    default:             state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_ALU, S_LOAD, S_STORE, S_BRANCH, S_JUMP:
                state_d = exec_next;
            S_HALT:    state_d = S_HALT;
            S_ILLEGAL: state_d = S_ILLEGAL;
`ifdef CU_STEP_EN
            S_WAIT:    state_d = bus.step ? S_FETCH : S_WAIT;
`endif
            default:   state_d = S_ILLEGAL;
        endcase
    end

    always_comb begin
        bus.w_en    = 1'b0;
        bus.s_sel   = 1'b0;
        bus.pc_ld   = 1'b0;
        bus.pc_inc  = 1'b0;
        bus.ir_ld   = 1'b0;
        bus.adr_sel = 1'b0;
        bus.pc_sel  = 1'b0;
        bus.mr_en   = 1'b0;
        bus.mw_en   = 1'b0;
        bus.ALU_OP  = ALU_PASS_R;
        bus.W_Adr   = ir[8:6];
        bus.R_Adr   = ir[5:3];
        bus.S_Adr   = ir[2:0];
        bus.halted  = (state_q == S_HALT) || (state_q == S_ILLEGAL);
        bus.state   = state_q;
        case (state_q)
            S_FETCH: begin
                bus.mr_en  = 1'b1;
                bus.ir_ld  = 1'b1;
                bus.pc_inc = 1'b1;
            end
            S_EXEC_ALU: begin
                bus.w_en   = 1'b1;
                bus.ALU_OP = ir[14:11];
            end
            S_LOAD: begin
                bus.adr_sel = 1'b1;
                bus.mr_en   = 1'b1;
                bus.s_sel   = 1'b1;
                bus.w_en    = 1'b1;
            end
            S_STORE: begin
                bus.adr_sel = 1'b1;
                bus.ALU_OP  = ALU_PASS_S;
                bus.mw_en   = 1'b1;
            end
            S_BRANCH: bus.pc_ld = taken;
            S_JUMP: begin
                bus.ALU_OP = ALU_PASS_R;
                bus.pc_sel = 1'b1;
                bus.pc_ld  = 1'b1;
            end
            default: ;
        endcase
        // Reset kills every strobe immediately, even mid-instruction.
        if (reset) begin
            bus.w_en    = 1'b0;
            bus.s_sel   = 1'b0;
            bus.pc_ld   = 1'b0;
            bus.pc_inc  = 1'b0;
            bus.ir_ld   = 1'b0;
            bus.adr_sel = 1'b0;
            bus.pc_sel  = 1'b0;
            bus.mr_en   = 1'b0;
            bus.mw_en   = 1'b0;
        end
    end
endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with an instruction-phase model.
// Build with +define+CU_STEP_EN to also exercise single-step.
module tb_cpu_control_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ir;
    logic        fc, fn, fz, step;

    always #5 clk = ~clk;

    cpu_cu_if bus();
    assign bus.ir_out = ir;
    assign bus.C      = fc;
    assign bus.N      = fn;
    assign bus.Z      = fz;
    assign bus.step   = step;

    cpu_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    localparam int P_RST = 0, P_FETCH = 1, P_DEC = 2;
    localparam int P_EXEC = 3, P_DEAD = 4, P_WAIT = 5;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2;
    localparam int K_BR = 3, K_JMP = 4, K_HALT = 5, K_ILL = 6;

    int         ph = P_RST;
    logic [2:0] flg = 3'b000;
    bit         chk_en = 1'b0;

    task automatic check(string nm, logic [15:0] a, logic [15:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic int kind(logic [15:0] i);
        if (!i[15]) return K_ALU;
        case (i[14:12])
            3'd0:    return K_LOAD;
            3'd1:    return K_STORE;
            3'd2:    return K_BR;
            3'd3:    return K_JMP;
            3'd7:    return K_HALT;
            default: return K_ILL;
        endcase
    endfunction

    // f = {C,N,Z}
    function automatic bit cond_true(logic [3:0] cd, logic [2:0] f);
        case (cd)
            4'd0:    return 1'b1;
            4'd1:    return f[0];
            4'd2:    return !f[0];
            4'd3:    return f[2];
            4'd4:    return !f[2];
            4'd5:    return f[1];
            4'd6:    return !f[1];
            default: return 1'b0;
        endcase
    endfunction

    // {w_en,s_sel,pc_ld,pc_inc,ir_ld,adr_sel,pc_sel,mr_en,mw_en,halted}
    function automatic logic [9:0] exp_vec();
        logic [8:0] s;
        logic       h;
        s = '0;
        h = (ph == P_DEAD);
        if (ph == P_FETCH) s = 9'b000110010;
        else if (ph == P_EXEC) begin
            case (kind(ir))
                K_ALU:   s = 9'b100000000;
                K_LOAD:  s = 9'b110001010;
                K_STORE: s = 9'b000001001;
                K_BR:    s = {2'b00, cond_true(ir[11:8], flg), 6'b0};
                K_JMP:   s = 9'b001000100;
                default: s = '0;
            endcase
        end
        if (reset) s = '0;
        return {s, h};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ph     = P_RST;
            flg    = 3'b000;
            chk_en = 1'b1;
        end else begin
            case (ph)
                P_RST:   ph = P_FETCH;
                P_FETCH: ph = P_DEC;
                P_DEC:   ph = (kind(ir) >= K_HALT) ? P_DEAD : P_EXEC;
                P_EXEC: begin
                    if (kind(ir) == K_ALU) flg = {fc, fn, fz};
`ifdef CU_STEP_EN
                    ph = P_WAIT;
`else
                    ph = P_FETCH;
`endif
                end
                P_WAIT:  if (step) ph = P_FETCH;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [9:0] act;
        if (chk_en) begin
            act = {bus.w_en, bus.s_sel, bus.pc_ld, bus.pc_inc, bus.ir_ld,
                   bus.adr_sel, bus.pc_sel, bus.mr_en, bus.mw_en, bus.halted};
            check("strobes", 16'(act), 16'(exp_vec()));
            if (ph == P_EXEC && !reset) begin
                case (kind(ir))
                    K_ALU: begin
                        check("alu_op", 16'(bus.ALU_OP), 16'(ir[14:11]));
                        check("w_adr", 16'(bus.W_Adr), 16'(ir[8:6]));
                        check("r_adr", 16'(bus.R_Adr), 16'(ir[5:3]));
                        check("s_adr", 16'(bus.S_Adr), 16'(ir[2:0]));
                    end
                    K_LOAD: begin
                        check("ld_w", 16'(bus.W_Adr), 16'(ir[8:6]));
                        check("ld_r", 16'(bus.R_Adr), 16'(ir[5:3]));
                    end
                    K_STORE: begin
                        check("st_op", 16'(bus.ALU_OP), 16'h1);
                        check("st_r", 16'(bus.R_Adr), 16'(ir[5:3]));
                        check("st_s", 16'(bus.S_Adr), 16'(ir[2:0]));
                    end
                    K_JMP: begin
                        check("jmp_op", 16'(bus.ALU_OP), 16'h0);
                        check("jmp_r", 16'(bus.R_Adr), 16'(ir[5:3]));
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic to_exec(logic [15:0] i, logic [2:0] f);
        ir = i;
        {fc, fn, fz} = f;
        cyc();
        cyc();
        #1;
    endtask

    task automatic leave_exec();
        cyc();
`ifdef CU_STEP_EN
        step = 1'b1;
        cyc();
        step = 1'b0;
`endif
    endtask

    task automatic run(logic [15:0] i, logic [2:0] f);
        to_exec(i, f);
        leave_exec();
    endtask

    initial begin
        reset = 1'b1;
        ir    = 16'h0000;
        {fc, fn, fz} = 3'b000;
        step  = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        #1;
        check("fetch_irld", 16'(bus.ir_ld), 16'h1);
        check("fetch_inc", 16'(bus.pc_inc), 16'h1);
        check("fetch_mr", 16'(bus.mr_en), 16'h1);

        // ALU op 2, W3 R1 S2, then reset for two cycles inside EXEC_ALU
        to_exec(16'h10CA, 3'b000);
        check("alu_w_en", 16'(bus.w_en), 16'h1);
        check("alu_W", 16'(bus.W_Adr), 16'h3);
        check("alu_R", 16'(bus.R_Adr), 16'h1);
        check("alu_S", 16'(bus.S_Adr), 16'h2);
        check("alu_OP", 16'(bus.ALU_OP), 16'h2);
        reset = 1'b1;
        #1;
        check("rst1_w_en", 16'(bus.w_en), 16'h0);
        cyc();
        check("rst2_w_en", 16'(bus.w_en), 16'h0);
        check("rst_halted", 16'(bus.halted), 16'h0);
        cyc();
        reset = 1'b0;
        cyc();
        #1;
        check("fetch2_adr", 16'(bus.adr_sel), 16'h0);
        check("fetch2_irld", 16'(bus.ir_ld), 16'h1);
        check("fetch2_inc", 16'(bus.pc_inc), 16'h1);

        // Branch on Z uses the latched flags, not the live ones
        run(16'h10CA, 3'b001);
        to_exec(16'hA1FE, 3'b000);
        check("brz_taken", 16'(bus.pc_ld), 16'h1);
        check("brz_sel", 16'(bus.pc_sel), 16'h0);
        leave_exec();
        run(16'h10CA, 3'b000);
        to_exec(16'hA1FE, 3'b001);
        check("brz_not", 16'(bus.pc_ld), 16'h0);
        leave_exec();

        // Set C, then LOAD/STORE must leave it intact
        run(16'h10CA, 3'b100);
        to_exec(16'h8150, 3'b000);
        check("ld_strb", 16'({bus.adr_sel, bus.mr_en, bus.s_sel, bus.w_en}), 16'hF);
        check("ld_W5", 16'(bus.W_Adr), 16'h5);
        check("ld_R2", 16'(bus.R_Adr), 16'h2);
        leave_exec();
        to_exec(16'h901C, 3'b000);
        check("st_mw", 16'(bus.mw_en), 16'h1);
        check("st_wen", 16'(bus.w_en), 16'h0);
        check("st_OP", 16'(bus.ALU_OP), 16'h1);
        leave_exec();
        to_exec(16'hA300, 3'b000);
        check("brc_kept", 16'(bus.pc_ld), 16'h1);
        leave_exec();

        to_exec(16'hB008, 3'b000);
        check("jmp_ld", 16'({bus.pc_ld, bus.pc_sel, bus.pc_inc}), 16'h6);
        check("jmp_OP", 16'(bus.ALU_OP), 16'h0);
        leave_exec();

        for (int k = 0; k < 16; k++) begin
            run(16'h7FC0 | 16'(k), 3'(k * 3));
            run({4'hA, 4'(k), 8'h05}, 3'(~k));
        end

        // Reset in the middle of a LOAD
        to_exec(16'h8150, 3'b000);
        reset = 1'b1;
        #1;
        check("ldrst_mr", 16'({bus.mr_en, bus.w_en}), 16'h0);
        cyc();
        reset = 1'b0;
        cyc();

        to_exec(16'hC000, 3'b000);
        for (int k = 0; k < 10; k++) begin
            check("ill_halted", 16'(bus.halted), 16'h1);
            cyc();
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check("ill_rst", 16'(bus.halted), 16'h0);
        cyc();

        to_exec(16'hF000, 3'b000);
        repeat (3) cyc();
        check("halt_h", 16'(bus.halted), 16'h1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();

`ifdef CU_STEP_EN
        run(16'h10CA, 3'b010);
        to_exec(16'h20CA, 3'b001);
        cyc();
        repeat (5) begin
            check("wait_irld", 16'(bus.ir_ld), 16'h0);
            cyc();
        end
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("step_fetch", 16'(bus.ir_ld), 16'h1);
        cyc();
`endif

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
